fetch_pc_ctrl: RTL and testbench

Fetch-stage PC sequencer and IF/ID buffer for the 5-stage pipeline. It holds the program counter and drives it to the PC+4 incrementer and to instruction memory. It selects the next PC from the incrementer result or a branch/jump redirect. Returned instructions are buffered in a small FIFO that feeds decode with a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 90 +++++++++
 rtl/fetch_pc_ctrl.sv | 101 ++++++++++
 tb/tb_fetch_pc_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
//   INSTR_W / ADDR_W : instruction and address widths
//   DEFAULT_RESET_PC : default PC loaded on reset
//   PC_STEP          : sequential PC increment
//   NOP_INSTR        : instruction value shown when the IF/ID head is empty
//   fetch_entry_t    : one IF/ID queue entry {instr, pc_plus4}
//   align_pc()       : clears the two low PC bits
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  PC_STEP          = 32'd4;
  localparam logic [ADDR_W-1:0]  PC_ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus4;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// IF/ID fetch queue: a small circular FIFO of fetch entries.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clear_i        : flush all entries (wins over enq_i/deq_i)
//   enq_i          : push enq_data_i (caller guarantees space)
//   deq_i          : pop the head (ignored while empty)
//   count_o        : number of valid entries
//   head_valid_o   : queue non-empty
//   head_o         : head entry, {NOP_INSTR, 0} while empty
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         enq_i,
  input  fetch_entry_t                 enq_data_i,
  input  logic                         deq_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         head_valid_o,
  output fetch_entry_t                 head_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  fetch_entry_t    mem_q [DEPTH];

  logic do_enq;
  logic do_deq;

  assign do_enq = enq_i & ~clear_i;
  assign do_deq = deq_i & ~clear_i & (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_enq) wptr_d = wptr_q + 1'b1;
      if (do_deq) rptr_d = rptr_q + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_enq) begin
      mem_q[wptr_q] <= enq_data_i;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != '0);

  always_comb begin
    head_o = '{instr: NOP_INSTR, pc_plus4: '0};
    if (head_valid_o) head_o = mem_q[rptr_q];
  end

  // Push into a full queue without a same-cycle pop would lose an entry.
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(do_enq && !do_deq && (count_q == CntW'(DEPTH))));

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer and IF/ID buffer.
//   clk, rst        : clock, synchronous active-high reset
//   pc_out          : current PC, drives the PC+4 incrementer and imem address
//   pc_plus4        : incrementer result for pc_out
//   imem_req        : fetch issued at pc_out this cycle
//   imem_rdata      : instruction, returned one cycle after imem_req
//   redirect_valid  : branch/jump taken; flushes fetch
//   redirect_pc     : redirect target (low two bits ignored)
//   id_ready        : decode can accept the head this cycle
//   if_id_valid     : queue head valid
//   if_id_instr     : queue head instruction
//   if_id_pc_plus4  : queue head PC+4
// Requests are credit-limited: one is issued only if a queue slot is still
// free after counting the response already in flight and this cycle's pop,
// so a response can always be enqueued the cycle it arrives.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic [ADDR_W-1:0]  pc_plus4,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_ready,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_plus4
);

  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] pc_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] tag_q;       // pc_plus4 of the request in flight

  logic [CntW-1:0]   q_count;
  logic              q_valid;
  fetch_entry_t      q_head;
  fetch_entry_t      q_enq_data;
  logic              q_enq;
  logic              deq;
  int                free_slots;

  assign deq        = q_valid & id_ready;
  assign free_slots = int'(DEPTH) - int'(q_count) - int'(inflight_q) + int'(deq);
  assign imem_req   = ~rst & ~redirect_valid & (free_slots > 0);

  // A response landing together with a redirect or reset is stale.
  assign q_enq      = inflight_q & ~redirect_valid & ~rst;
  assign q_enq_data = '{instr: imem_rdata, pc_plus4: tag_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= align_pc(RESET_PC);
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else if (redirect_valid) begin
      pc_q       <= align_pc(redirect_pc);
      inflight_q <= 1'b0;
    end else if (imem_req) begin
      pc_q       <= align_pc(pc_plus4);
      inflight_q <= 1'b1;
      tag_q      <= pc_plus4;
    end else begin
      inflight_q <= 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (redirect_valid),
    .enq_i        (q_enq),
    .enq_data_i   (q_enq_data),
    .deq_i        (deq),
    .count_o      (q_count),
    .head_valid_o (q_valid),
    .head_o       (q_head)
  );

  assign pc_out         = pc_q;
  assign if_id_valid    = q_valid;
  assign if_id_instr    = q_head.instr;
  assign if_id_pc_plus4 = q_head.pc_plus4;

  // The credit rule keeps the slot budget non-negative.
  assert property (@(posedge clk) disable iff (rst) free_slots >= 0);

  // The external incrementer is expected to track pc_out.
  assert property (@(posedge clk) disable iff (rst)
    imem_req |-> (pc_plus4 == pc_out + PC_STEP));

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // DUT with default reset PC
  logic [31:0] pc_out, pc_plus4, imem_rdata, if_id_instr, if_id_pc_plus4;
  logic        imem_req, if_id_valid;

  // DUT near the top of the address space
  logic [31:0] pc_out2, pc_plus4_2, imem_rdata2, if_id_instr2, if_id_pc_plus4_2;
  logic        imem_req2, if_id_valid2;

  int checks;
  int failures;

  fetch_pc_ctrl #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .imem_req       (imem_req),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4)
  );

  fetch_pc_ctrl #(
    .RESET_PC (32'hFFFF_FFF8),
    .DEPTH    (2)
  ) dut_hi (
    .clk            (clk),
    .rst            (rst),
    .pc_out         (pc_out2),
    .pc_plus4       (pc_plus4_2),
    .imem_req       (imem_req2),
    .imem_rdata     (imem_rdata2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0000_0000),
    .id_ready       (id_ready),
    .if_id_valid    (if_id_valid2),
    .if_id_instr    (if_id_instr2),
    .if_id_pc_plus4 (if_id_pc_plus4_2)
  );

  // Incrementers and address-as-data instruction memories
  assign pc_plus4   = pc_out + 32'd4;
  assign pc_plus4_2 = pc_out2 + 32'd4;

  always_ff @(posedge clk) begin
    imem_rdata  <= imem_req  ? pc_out  : 32'hBAD0_BAD0;
    imem_rdata2 <= imem_req2 ? pc_out2 : 32'hBAD0_BAD0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic req, input logic [31:0] pc,
                               input logic valid, input logic [31:0] instr,
                               input logic [31:0] p4);
    check_eq({tag, ".req"},   {31'd0, imem_req},    {31'd0, req});
    check_eq({tag, ".pc"},    pc_out,               pc);
    check_eq({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    check_eq({tag, ".instr"}, if_id_instr,          instr);
    check_eq({tag, ".pc4"},   if_id_pc_plus4,       p4);
  endtask

  // Two-cycle reset; returns just after the negedge where rst drops (cycle 0).
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset values and streaming with id_ready=1
    @(negedge clk);
    @(negedge clk);
    #1;
    check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    check_eq("hi.reset_pc", pc_out2, 32'hFFFF_FFF8);
    check_eq("hi.reset_req", {31'd0, imem_req2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs("t1c0", 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
    check_eq("hi.c0_pc", pc_out2, 32'hFFFF_FFF8);
    @(negedge clk); #1;
    check_outputs("t1c1", 1'b1, 32'd4, 1'b0, 32'd0, 32'd0);
    check_eq("hi.c1_pc", pc_out2, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check_outputs("t1c2", 1'b1, 32'd8, 1'b1, 32'd0, 32'd4);
    check_eq("hi.c2_pc", pc_out2, 32'h0000_0000);
    check_eq("hi.c2_instr", if_id_instr2, 32'hFFFF_FFF8);
    check_eq("hi.c2_pc4", if_id_pc_plus4_2, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check_outputs("t1c3", 1'b1, 32'd12, 1'b1, 32'd4, 32'd8);
    check_eq("hi.c3_instr", if_id_instr2, 32'hFFFF_FFFC);
    check_eq("hi.c3_pc4", if_id_pc_plus4_2, 32'h0000_0000);
    @(negedge clk); #1;
    check_outputs("t1c4", 1'b1, 32'd16, 1'b1, 32'd8, 32'd12);
    check_eq("hi.c4_instr", if_id_instr2, 32'h0000_0000);
    check_eq("hi.c4_pc4", if_id_pc_plus4_2, 32'h0000_0004);

    // One-cycle reset pulse with a response pending
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("t6.req_in_rst", {31'd0, imem_req}, 32'd0);
    @(negedge clk); #1;
    check_outputs("t6rst", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    check_eq("hi.t6rst_pc", pc_out2, 32'hFFFF_FFF8);
    rst = 1'b0;
    #1;
    check_outputs("t6c0", 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk); #1;
    check_outputs("t6c1", 1'b1, 32'd4, 1'b0, 32'd0, 32'd0);
    @(negedge clk); #1;
    check_outputs("t6c2", 1'b1, 32'd8, 1'b1, 32'd0, 32'd4);

    // Back-pressure: queue fills, fetch stalls, then drains in order
    do_reset();
    id_ready = 1'b0;
    #1;
    check_outputs("t2c0", 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk); #1;
    check_outputs("t2c1", 1'b1, 32'd4, 1'b0, 32'd0, 32'd0);
    @(negedge clk); #1;
    check_outputs("t2c2", 1'b0, 32'd8, 1'b1, 32'd0, 32'd4);
    for (int i = 3; i < 6; i++) begin
      @(negedge clk); #1;
      check_outputs("t2hold", 1'b0, 32'd8, 1'b1, 32'd0, 32'd4);
    end
    @(negedge clk);
    id_ready = 1'b1;
    #1;
    check_outputs("t2c6", 1'b1, 32'd8, 1'b1, 32'd0, 32'd4);
    @(negedge clk); #1;
    check_outputs("t2c7", 1'b1, 32'd12, 1'b1, 32'd4, 32'd8);
    @(negedge clk); #1;
    check_outputs("t2c8", 1'b1, 32'd16, 1'b1, 32'd8, 32'd12);
    @(negedge clk); #1;
    check_outputs("t2c9", 1'b1, 32'd20, 1'b1, 32'd12, 32'd16);

    // Redirect with full credit and a response in flight
    do_reset();
    id_ready = 1'b0;
    #1;
    check_outputs("t3c0", 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk); #1;
    check_outputs("t3c1", 1'b1, 32'd4, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    check_outputs("t3redir", 1'b0, 32'd8, 1'b1, 32'd0, 32'd4);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check_outputs("t3c3", 1'b1, 32'h100, 1'b0, 32'd0, 32'd0);
    @(negedge clk); #1;
    check_outputs("t3c4", 1'b1, 32'h104, 1'b0, 32'd0, 32'd0);
    @(negedge clk); #1;
    check_outputs("t3c5", 1'b0, 32'h108, 1'b1, 32'h100, 32'h104);
    @(negedge clk);
    id_ready = 1'b1;
    #1;
    check_outputs("t3c6", 1'b1, 32'h108, 1'b1, 32'h100, 32'h104);
    @(negedge clk); #1;
    check_outputs("t3c7", 1'b1, 32'h10C, 1'b1, 32'h104, 32'h108);

    // Redirect together with a consumed head at a full queue
    do_reset();
    id_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    check_outputs("t4redir", 1'b0, 32'd8, 1'b1, 32'd0, 32'd4);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check_outputs("t4c4", 1'b1, 32'h200, 1'b0, 32'd0, 32'd0);
    @(negedge clk); #1;
    check_outputs("t4c5", 1'b1, 32'h204, 1'b0, 32'd0, 32'd0);
    @(negedge clk); #1;
    check_outputs("t4c6", 1'b1, 32'h208, 1'b1, 32'h200, 32'h204);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
